// File: rtl/dbus_mem_responder.sv
// rtl/dbus_mem_responder.sv - dBus responder RAM with byte-lane writes and fixed-latency word reads
//
// Purpose:
//   Single-port word RAM serving a CPU data port over the dBus command/response
//   handshake. Writes are absorbed in one cycle with lane placement and never
//   produce a response. A read parks the responder in BUSY for RSP_LATENCY
//   cycles. During the last BUSY cycle the full aligned word is presented with
//   a one-cycle dBus_rsp_ready pulse. The requester extracts the lanes it needs.
//
// Optional feature:
//   DBUS_MEM_ERR_CHECK_EN - when defined, a command is rejected as an error if
//   any of the following holds: size 3; a misaligned halfword or word; or a
//   word index at or beyond MEM_WORDS. An errored write is dropped silently.
//   An errored read responds with error=1 and data=0. When the macro is not
//   defined, the error line stays at 0, the word index wraps modulo MEM_WORDS,
//   and size 3 acts as a word access.
//
// Ports:
//   clk_cpu, clk_cpu_reset       clock, synchronous active-high reset
//   dBus_cmd_valid/ready         command handshake (ready low while BUSY)
//   dBus_cmd_payload_wr          1 = write, 0 = read
//   dBus_cmd_payload_address     byte address, word index = address[31:2]
//   dBus_cmd_payload_data        write data (byte in [7:0], halfword in [15:0])
//   dBus_cmd_payload_size        0 byte, 1 halfword, 2 word, 3 illegal
//   dBus_rsp_ready               one-cycle read response strobe
//   dBus_rsp_error               access error, qualifies dBus_rsp_ready
//   dBus_rsp_data                aligned read word, held between responses

module dbus_mem_responder #(
  parameter int MEM_WORDS   = 4096,
  parameter int RSP_LATENCY = 1
) (
  input  logic        clk_cpu,
  input  logic        clk_cpu_reset,
  input  logic        dBus_cmd_valid,
  output logic        dBus_cmd_ready,
  input  logic        dBus_cmd_payload_wr,
  input  logic [31:0] dBus_cmd_payload_address,
  input  logic [31:0] dBus_cmd_payload_data,
  input  logic [1:0]  dBus_cmd_payload_size,
  output logic        dBus_rsp_ready,
  output logic        dBus_rsp_error,
  output logic [31:0] dBus_rsp_data
);

  localparam int AW = $clog2(MEM_WORDS);
  // The counter holds the BUSY cycles still to pass before the response is
  // registered. Loading LATENCY-1 places the strobe in the last BUSY cycle.
  // With latency 1, the strobe is registered on the accept edge itself.
  localparam logic [3:0] LAT_M1 = 4'(RSP_LATENCY - 1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic          rsp_ready_q, rsp_ready_d;
  logic          rsp_error_q, rsp_error_d;
  logic [31:0]   rsp_data_q, rsp_data_d;

  logic [31:0]   mem_q [MEM_WORDS];

  logic [AW-1:0] cmd_idx;
  logic          cmd_err;
  logic          accept;
  logic          wr_en;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          rsp_fire;
  logic [AW-1:0] rsp_idx;
  logic          rsp_err;

  assign cmd_idx = dBus_cmd_payload_address[AW+1:2];

`ifdef DBUS_MEM_ERR_CHECK_EN
  always_comb begin
    cmd_err = 1'b0;
    case (dBus_cmd_payload_size)
      2'd1:    cmd_err = dBus_cmd_payload_address[0];
      2'd2:    cmd_err = (dBus_cmd_payload_address[1:0] != 2'b00);
      2'd3:    cmd_err = 1'b1;
      default: cmd_err = 1'b0;
    endcase
    // Any word-index bit above the array size means out of range.
    if ((dBus_cmd_payload_address[31:2] >> AW) != '0) begin
      cmd_err = 1'b1;
    end
  end
`else
  // The upper index bits are discarded, so the index wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^dBus_cmd_payload_address[31:AW+2];
  assign cmd_err        = 1'b0;
`endif

  assign dBus_cmd_ready = (state_q == ST_IDLE);
  assign accept         = dBus_cmd_valid && (state_q == ST_IDLE);
  assign wr_en          = accept && dBus_cmd_payload_wr && !cmd_err && !clk_cpu_reset;

  // Lane placement: replicate the narrow data across every lane and let the
  // byte enables choose which lanes actually change.
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = dBus_cmd_payload_data;
    case (dBus_cmd_payload_size)
      2'd0: begin
        wr_be   = 4'b0001 << dBus_cmd_payload_address[1:0];
        wr_data = {4{dBus_cmd_payload_data[7:0]}};
      end
      2'd1: begin
        wr_be   = dBus_cmd_payload_address[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{dBus_cmd_payload_data[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = dBus_cmd_payload_data;
      end
    endcase
  end

  // Memory has no reset: its contents stay undefined until written.
  always_ff @(posedge clk_cpu) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem_q[cmd_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    err_d       = err_q;
    rsp_ready_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_data_d  = rsp_data_q;
    rsp_fire    = 1'b0;
    rsp_idx     = cmd_idx;
    rsp_err     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept && !dBus_cmd_payload_wr) begin
          state_d  = ST_BUSY;
          idx_d    = cmd_idx;
          err_d    = cmd_err;
          cnt_d    = LAT_M1;
          rsp_fire = (LAT_M1 == 4'd0);
          rsp_idx  = cmd_idx;
          rsp_err  = cmd_err;
        end
      end
      ST_BUSY: begin
        if (rsp_ready_q) begin
          // The strobe cycle is the last BUSY cycle.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          rsp_fire = (cnt_q == 4'd1);
          rsp_idx  = idx_q;
          rsp_err  = err_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rsp_fire) begin
      rsp_ready_d = 1'b1;
      rsp_error_d = rsp_err;
      rsp_data_d  = rsp_err ? 32'h0 : mem_q[rsp_idx];
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (clk_cpu_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      rsp_ready_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign dBus_rsp_ready = rsp_ready_q;
  assign dBus_rsp_error = rsp_error_q;
  assign dBus_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb/tb_dbus_mem_responder.sv - bench for dbus_mem_responder at latencies 1 and 4

module tb_dbus_mem_responder;

  localparam int MEM_WORDS = 4096;
  localparam int LAT_A     = 1;
  localparam int LAT_B     = 4;

  logic        clk;
  logic        rst    [2];
  logic        cvalid [2];
  logic        cwr    [2];
  logic [31:0] caddr  [2];
  logic [31:0] cdata  [2];
  logic [1:0]  csize  [2];
  logic        crdy   [2];
  logic        rrdy   [2];
  logic        rerr   [2];
  logic [31:0] rdat   [2];

  dbus_mem_responder #(.MEM_WORDS(MEM_WORDS), .RSP_LATENCY(LAT_A)) dut_a (
    .clk_cpu                  (clk),
    .clk_cpu_reset            (rst[0]),
    .dBus_cmd_valid           (cvalid[0]),
    .dBus_cmd_ready           (crdy[0]),
    .dBus_cmd_payload_wr      (cwr[0]),
    .dBus_cmd_payload_address (caddr[0]),
    .dBus_cmd_payload_data    (cdata[0]),
    .dBus_cmd_payload_size    (csize[0]),
    .dBus_rsp_ready           (rrdy[0]),
    .dBus_rsp_error           (rerr[0]),
    .dBus_rsp_data            (rdat[0])
  );

  dbus_mem_responder #(.MEM_WORDS(MEM_WORDS), .RSP_LATENCY(LAT_B)) dut_b (
    .clk_cpu                  (clk),
    .clk_cpu_reset            (rst[1]),
    .dBus_cmd_valid           (cvalid[1]),
    .dBus_cmd_ready           (crdy[1]),
    .dBus_cmd_payload_wr      (cwr[1]),
    .dBus_cmd_payload_address (caddr[1]),
    .dBus_cmd_payload_data    (cdata[1]),
    .dBus_cmd_payload_size    (csize[1]),
    .dBus_rsp_ready           (rrdy[1]),
    .dBus_rsp_error           (rerr[1]),
    .dBus_rsp_data            (rdat[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Literal expectations posted by the stimulus for the next response.
  int          lit_req  [2] = '{0, 0};
  int          lit_done [2] = '{0, 0};
  logic [31:0] lit_data [2];
  logic        lit_err  [2];
  int          lit_lat  [2];

  // Behavioural model state
  int          n = 0;
  bit          armed      [2] = '{0, 0};
  int          ready_from [2] = '{0, 0};
  int          rsp_at     [2] = '{-1, -1};
  int          acc_cyc    [2] = '{0, 0};
  logic [31:0] exp_data   [2];
  logic        exp_err    [2];
  logic [31:0] pend_data  [2];
  logic        pend_err   [2];
  logic [31:0] mmod [longint];
  int          lat_of [2] = '{LAT_A, LAT_B};

  function automatic int nbytes_of(logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_err(logic [31:0] a, logic [1:0] sz);
`ifdef DBUS_MEM_ERR_CHECK_EN
    return (sz == 2'd3) || ((a % nbytes_of(sz)) != 0) || ((a >> 2) >= MEM_WORDS);
`else
    return 1'b0;
`endif
  endfunction

  function automatic longint model_key(int d, logic [31:0] a);
    longint idx;
    idx = longint'(a >> 2) % MEM_WORDS;
    return longint'(d) * 64'h1_0000_0000 + idx;
  endfunction

  function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, n, act, exp);
    end
  endfunction

  // Compare and model-advance process: checks this cycle, then applies the
  // coming edge to the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (armed[d]) begin
        if (n == rsp_at[d]) begin
          exp_data[d] = pend_data[d];
          exp_err[d]  = pend_err[d];
        end
        chk("cmd_ready", d, 32'(crdy[d]), 32'(n >= ready_from[d]));
        chk("rsp_ready", d, 32'(rrdy[d]), 32'(n == rsp_at[d]));
        chk("rsp_data", d, rdat[d], exp_data[d]);
        chk("rsp_error", d, 32'(rerr[d]), 32'(exp_err[d]));
        if (rrdy[d] === 1'b1 && lit_req[d] != lit_done[d]) begin
          chk("lit_data", d, rdat[d], lit_data[d]);
          chk("lit_error", d, 32'(rerr[d]), 32'(lit_err[d]));
          chk("lit_latency", d, 32'(n - acc_cyc[d]), 32'(lit_lat[d]));
          chk("model_vs_lit", d, exp_data[d], lit_data[d]);
          lit_done[d] = lit_req[d];
        end
      end

      if (rst[d] === 1'b1) begin
        armed[d]      = 1'b1;
        ready_from[d] = n + 1;
        rsp_at[d]     = -1;
        exp_data[d]   = 32'h0;
        exp_err[d]    = 1'b0;
      end else if (armed[d] && cvalid[d] === 1'b1 && n >= ready_from[d]) begin
        longint      k;
        logic [31:0] w;
        int          nb;
        int          first;
        k = model_key(d, caddr[d]);
        if (cwr[d]) begin
          if (!model_err(caddr[d], csize[d])) begin
            nb    = nbytes_of(csize[d]);
            first = (caddr[d] % 4) - ((caddr[d] % 4) % nb);
            w     = mmod.exists(k) ? mmod[k] : 32'hx;
            for (int b = 0; b < nb; b++) begin
              w[(first + b) * 8 +: 8] = cdata[d][b * 8 +: 8];
            end
            mmod[k] = w;
          end
        end else begin
          acc_cyc[d]    = n;
          rsp_at[d]     = n + lat_of[d];
          ready_from[d] = n + lat_of[d] + 1;
          pend_err[d]   = model_err(caddr[d], csize[d]);
          pend_data[d]  = pend_err[d] ? 32'h0 : (mmod.exists(k) ? mmod[k] : 32'hx);
        end
      end
    end
    n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(int d, logic wr, logic [31:0] a, logic [31:0] data, logic [1:0] sz);
    cvalid[d] = 1'b1;
    cwr[d]    = wr;
    caddr[d]  = a;
    cdata[d]  = data;
    csize[d]  = sz;
    tick();
    cvalid[d] = 1'b0;
  endtask

  task automatic rd(int d, logic [31:0] a, logic [1:0] sz, logic [31:0] ld, logic le, int ll);
    lit_data[d] = ld;
    lit_err[d]  = le;
    lit_lat[d]  = ll;
    lit_req[d]  = lit_req[d] + 1;
    cmd(d, 1'b0, a, 32'h0, sz);
    repeat (ll) tick();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d]    = 1'b1;
      cvalid[d] = 1'b0;
      cwr[d]    = 1'b0;
      caddr[d]  = 32'h0;
      cdata[d]  = 32'h0;
      csize[d]  = 2'd2;
    end
    repeat (3) tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    // Latency 1: word write and read back
    cmd(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2);
    rd(0, 32'h10, 2'd2, 32'hDEADBEEF, 1'b0, 1);

    // Byte lanes, written back to back
    cmd(0, 1'b1, 32'h20, 32'h0, 2'd2);
    cmd(0, 1'b1, 32'h20, 32'h11, 2'd0);
    cmd(0, 1'b1, 32'h21, 32'h22, 2'd0);
    cmd(0, 1'b1, 32'h22, 32'h33, 2'd0);
    cmd(0, 1'b1, 32'h23, 32'h44, 2'd0);
    rd(0, 32'h20, 2'd2, 32'h44332211, 1'b0, 1);

    // Upper halfword
    cmd(0, 1'b1, 32'h20, 32'h11111111, 2'd2);
    cmd(0, 1'b1, 32'h22, 32'h0000ABCD, 2'd1);
    rd(0, 32'h20, 2'd2, 32'hABCD1111, 1'b0, 1);

    cmd(0, 1'b1, 32'h0, 32'h0BADF00D, 2'd2);
`ifdef DBUS_MEM_ERR_CHECK_EN
    rd(0, 32'h22, 2'd2, 32'h0, 1'b1, 1);
    rd(0, 32'h4000, 2'd2, 32'h0, 1'b1, 1);
    rd(0, 32'h20, 2'd3, 32'h0, 1'b1, 1);
    cmd(0, 1'b1, 32'h21, 32'h5555, 2'd1);
    rd(0, 32'h20, 2'd2, 32'hABCD1111, 1'b0, 1);
`else
    rd(0, 32'h22, 2'd2, 32'hABCD1111, 1'b0, 1);
    rd(0, 32'h4000, 2'd2, 32'h0BADF00D, 1'b0, 1);
    rd(0, 32'h20, 2'd3, 32'hABCD1111, 1'b0, 1);
    cmd(0, 1'b1, 32'h21, 32'h5555, 2'd1);
    rd(0, 32'h20, 2'd2, 32'hABCD5555, 1'b0, 1);
`endif

    // Reset wins over a write in the same cycle
    rst[0]    = 1'b1;
    cvalid[0] = 1'b1;
    cwr[0]    = 1'b1;
    caddr[0]  = 32'h10;
    cdata[0]  = 32'h0;
    csize[0]  = 2'd2;
    tick();
    rst[0]    = 1'b0;
    cvalid[0] = 1'b0;
    tick();
    rd(0, 32'h10, 2'd2, 32'hDEADBEEF, 1'b0, 1);

    // Latency 4: a write held valid through BUSY is accepted once idle
    cmd(1, 1'b1, 32'h40, 32'hCAFE0001, 2'd2);
    lit_data[1] = 32'hCAFE0001;
    lit_err[1]  = 1'b0;
    lit_lat[1]  = 4;
    lit_req[1]  = lit_req[1] + 1;
    cvalid[1] = 1'b1;
    cwr[1]    = 1'b0;
    caddr[1]  = 32'h40;
    csize[1]  = 2'd2;
    tick();
    cwr[1]    = 1'b1;
    caddr[1]  = 32'h44;
    cdata[1]  = 32'h12345678;
    repeat (5) tick();
    cvalid[1] = 1'b0;
    tick();
    rd(1, 32'h44, 2'd2, 32'h12345678, 1'b0, 4);

    // Reset in the second BUSY cycle discards the read
    cmd(1, 1'b1, 32'h48, 32'hA5A5A5A5, 2'd2);
    cmd(1, 1'b0, 32'h48, 32'h0, 2'd2);
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    repeat (6) tick();
    rd(1, 32'h48, 2'd2, 32'hA5A5A5A5, 1'b0, 4);
    rd(1, 32'h40, 2'd2, 32'hCAFE0001, 1'b0, 4);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
